// File: rtl/imem_loader.sv
// Boot-time IMEM loader: takes a byte stream (LE word count, LE data words, XOR checksum),
// writes words sequentially from BASE_ADDR and holds the core in reset until the image verifies.
module imem_loader #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  byte_cnt;
    logic [31:0] word_cnt;
    logic [31:0] word_len;
    logic [23:0] asm_lo;
    logic [7:0]  csum;

    logic        accept;
    logic        last_byte;
    logic        last_word;
    logic        len_ok;
    logic        start_ok;
    logic        load_next;
    logic [31:0] full_word;

    // Handshake: a byte moves on any edge where rx_valid && rx_ready; rx_ready is a
    // registered function of state only, so the source may hold rx_valid across gaps freely.
    assign accept    = rx_valid && rx_ready;
    assign last_byte = (byte_cnt == 2'd3);
    assign full_word = {rx_data, asm_lo};
    assign last_word = (word_cnt == word_len - 32'd1);
    assign len_ok    = (full_word != 32'd0) && (full_word <= 32'(DEPTH_WORDS));
    assign start_ok  = start && (state == IDLE || state == DONE || state == ERR);
    assign load_next = (state_next == HDR) || (state_next == DATA) || (state_next == CSUM);

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_next = HDR;
            HDR:  if (accept && last_byte) state_next = len_ok ? DATA : ERR;
            DATA: if (accept && last_byte && last_word) state_next = CSUM;
            CSUM: if (accept) state_next = (rx_data == csum) ? DONE : ERR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            byte_cnt <= 2'd0;
            word_cnt <= 32'd0;
            word_len <= 32'd0;
            asm_lo   <= 24'd0;
            csum     <= 8'd0;
            rx_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= 32'd0;
            wr_data  <= 32'd0;
            cpu_hold <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            rx_ready <= load_next;
            busy     <= load_next;
            done     <= (state_next == DONE);
            err      <= (state_next == ERR);
            cpu_hold <= (state_next != DONE);
            wr_en    <= 1'b0;

            if (start_ok) begin
                byte_cnt <= 2'd0;
                word_cnt <= 32'd0;
                csum     <= 8'd0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    asm_lo[7:0]   <= rx_data;
                    2'd1:    asm_lo[15:8]  <= rx_data;
                    2'd2:    asm_lo[23:16] <= rx_data;
                    default: asm_lo        <= asm_lo;
                endcase
                if (state == HDR && last_byte) begin
                    word_len <= full_word;
                end
                if (state == DATA) begin
                    // Header and checksum bytes are deliberately excluded from the XOR.
                    csum <= csum ^ rx_data;
                    if (last_byte) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= BASE_ADDR + (word_cnt << 2);
                        wr_data  <= full_word;
                        word_cnt <= word_cnt + 32'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: drives byte streams with optional valid gaps and
// scoreboards every IMEM write against the image that was sent.
module tb_imem_loader;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          wr_count = 0;
    bit          ready_watch = 1'b0;
    bit          ready_dropped = 1'b0;
    logic [31:0] img[8];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wr_en) begin
            wr_count++;
            if (exp_addr_q.size() == 0) begin
                check_eq("wr_unexpected", 32'd1, 32'd0);
            end else begin
                check_eq("wr_addr", wr_addr, exp_addr_q.pop_front());
                check_eq("wr_data", wr_data, exp_data_q.pop_front());
            end
        end
        if (ready_watch && !rx_ready) ready_dropped = 1'b1;
    end

    // ---------------- driver tasks ----------------
    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int n;
        gap = $urandom_range(max_gap, 0);
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 20) check_eq("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("start_ready", {31'd0, rx_ready}, 32'd1);
        check_eq("start_busy", {31'd0, busy}, 32'd1);
        check_eq("start_clr_done", {31'd0, done}, 32'd0);
        check_eq("start_clr_err", {31'd0, err}, 32'd0);
        check_eq("start_hold", {31'd0, cpu_hold}, 32'd1);
    endtask

    task automatic run_load(input int n, input int max_gap, input bit force_csum,
                            input logic [7:0] csum_val, input int poke);
        logic [31:0] nv;
        logic [31:0] w;
        logic [7:0]  x;
        logic [7:0]  sent;
        int          c0;
        int          w0;
        nv = n;
        x  = 8'd0;
        c0 = cyc;
        w0 = wr_count;
        do_start();
        ready_watch   = 1'b1;
        ready_dropped = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(nv[8*i +: 8], max_gap);
        if (n < 1 || n > DEPTH) begin
            ready_watch = 1'b0;
            check_eq("hdr_err", {31'd0, err}, 32'd1);
            check_eq("hdr_done", {31'd0, done}, 32'd0);
            check_eq("hdr_hold", {31'd0, cpu_hold}, 32'd1);
            check_eq("hdr_ready", {31'd0, rx_ready}, 32'd0);
            check_eq("hdr_busy", {31'd0, busy}, 32'd0);
            repeat (3) @(posedge clk);
            #1;
            check_eq("hdr_no_writes", wr_count, w0);
        end else begin
            for (int k = 0; k < n; k++) begin
                if (k == poke) begin
                    start = 1'b1;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                    check_eq("poke_busy", {31'd0, busy}, 32'd1);
                    check_eq("poke_ready", {31'd0, rx_ready}, 32'd1);
                end
                w = img[k];
                exp_addr_q.push_back(BASE + 32'(4 * k));
                exp_data_q.push_back(w);
                for (int i = 0; i < 4; i++) begin
                    x = x ^ w[8*i +: 8];
                    send_byte(w[8*i +: 8], max_gap);
                    if (i == 3) check_eq("wr_latency", {31'd0, wr_en}, 32'd1);
                end
            end
            sent = force_csum ? csum_val : x;
            send_byte(sent, max_gap);
            ready_watch = 1'b0;
            check_eq("ready_held", {31'd0, ready_dropped}, 32'd0);
            check_eq("n_writes", wr_count - w0, n);
            check_eq("busy_end", {31'd0, busy}, 32'd0);
            check_eq("ready_end", {31'd0, rx_ready}, 32'd0);
            if (sent == x) begin
                check_eq("done", {31'd0, done}, 32'd1);
                check_eq("err_clear", {31'd0, err}, 32'd0);
                check_eq("hold_release", {31'd0, cpu_hold}, 32'd0);
                if (max_gap == 0 && poke < 0) check_eq("load_cycles", cyc - c0, 6 + 4 * n);
            end else begin
                check_eq("csum_err", {31'd0, err}, 32'd1);
                check_eq("csum_done", {31'd0, done}, 32'd0);
                check_eq("csum_hold", {31'd0, cpu_hold}, 32'd1);
            end
        end
        check_eq("scb_empty", exp_addr_q.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, {31'd0, rx_ready}, 32'd0);
        check_eq({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        check_eq({tag, "_wr_addr"}, wr_addr, 32'd0);
        check_eq({tag, "_wr_data"}, wr_data, 32'd0);
        check_eq({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
        check_eq({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] w;
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic two-word image, back-to-back bytes.
        img[0] = 32'h0000_0013;
        img[1] = 32'h0040_0093;
        run_load(2, 0, 1'b0, 8'd0, -1);

        // Same image with random valid gaps.
        run_load(2, 7, 1'b0, 8'd0, -1);

        // Bad lengths.
        run_load(0, 0, 1'b0, 8'd0, -1);
        run_load(DEPTH + 1, 0, 1'b0, 8'd0, -1);

        // Checksum mismatch then recovery.
        img[0] = 32'hDEAD_BEEF;
        run_load(1, 0, 1'b1, 8'h00, -1);
        run_load(1, 0, 1'b0, 8'd0, -1);

        // Asynchronous reset after 6 data bytes.
        img[0] = 32'h0000_0013;
        img[1] = 32'h0040_0093;
        do_start();
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'd2 : 8'd0, 0);
        exp_addr_q.push_back(BASE);
        exp_data_q.push_back(img[0]);
        w = img[0];
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 0);
        w = img[1];
        for (int i = 0; i < 2; i++) send_byte(w[8*i +: 8], 0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("post_rst");
        run_load(2, 0, 1'b0, 8'd0, -1);

        // start pulsed mid-DATA is ignored.
        for (int k = 0; k < 3; k++) img[k] = $urandom;
        run_load(3, 2, 1'b0, 8'd0, 1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
